// File: rtl/mem_arbiter_nch.sv
// Arbitrates NUM_CH request channels (fetch/load/store) onto a byte-serial RAM/IO bus.
// Latency: grant one edge after capture; an N-byte read acks N+1 cycles after capture, an N-byte write after N+1 cycles plus IO bubbles.
// Backpressure: one pending slot per channel (ch_ready_out = slot empty); rdy_in low freezes everything.
//
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global enable), flush_in (cancels reads)
//   ch_req_in/ch_we_in/ch_addr_in/ch_wdata_in/ch_size_in : per-channel request, slice i = channel i
//   ch_ready_out, ch_ack_out (one-hot pulse), ch_rdata_out (valid with a read ack)
//   mem_din_in, mem_dout_out, mem_a_out, mem_wr_out : byte bus; io_buffer_full_in paces IO_ADDR writes
module mem_arbiter_nch #(
    parameter int                NUM_CH    = 3,
    parameter int                ADDR_W    = 32,
    parameter int                MAX_BYTES = 4,
    parameter int                ARB_MODE  = 1,
    parameter logic [ADDR_W-1:0] IO_ADDR   = 'h30000
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          flush_in,
    input  logic [NUM_CH-1:0]             ch_req_in,
    input  logic [NUM_CH-1:0]             ch_we_in,
    input  logic [NUM_CH*ADDR_W-1:0]      ch_addr_in,
    input  logic [NUM_CH*8*MAX_BYTES-1:0] ch_wdata_in,
    input  logic [NUM_CH*3-1:0]           ch_size_in,
    output logic [NUM_CH-1:0]             ch_ready_out,
    output logic [NUM_CH-1:0]             ch_ack_out,
    output logic [8*MAX_BYTES-1:0]        ch_rdata_out,
    input  logic [7:0]                    mem_din_in,
    input  logic                          io_buffer_full_in,
    output logic [7:0]                    mem_dout_out,
    output logic [ADDR_W-1:0]             mem_a_out,
    output logic                          mem_wr_out
);

    localparam int DW   = 8 * MAX_BYTES;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

    // pending slots
    logic [NUM_CH-1:0] pend_r, pend_we_r, pend_nxt, cap_v;
    logic [ADDR_W-1:0] pend_addr_r  [NUM_CH];
    logic [DW-1:0]     pend_wdata_r [NUM_CH];
    logic [2:0]        pend_size_r  [NUM_CH];

    // access engine
    state_t            state_r, state_nxt;
    logic [2:0]        cnt_r, cnt_nxt;
    logic [2:0]        size_r, size_nxt;
    logic [ADDR_W-1:0] start_r, start_nxt;
    logic [DW-1:0]     data_r, data_nxt;
    logic [CH_W-1:0]   gnt_r, gnt_nxt;
    logic [CH_W-1:0]   rr_r, rr_nxt;

    logic [ADDR_W-1:0] a_nxt;
    logic [7:0]        dout_nxt;
    logic              wr_nxt;
    logic [NUM_CH-1:0] ack_nxt;
    logic [DW-1:0]     rdata_nxt;
    logic [NUM_CH-1:0] gnt_clr;

    // arbitration
    logic [NUM_CH-1:0] elig;
    logic              pick_vld;
    logic [CH_W-1:0]   pick_idx;

    // datapath helpers
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_byte;
    logic [DW-1:0]     rd_merge;
    logic              io_last;
    logic              io_hold_cur;
    logic              io_hold_gnt;

    assign ch_ready_out = ~pend_r;

    // A flush edge must not grant a read that the same edge is cancelling.
    always_comb begin
        int j;
        j        = 0;
        elig     = pend_r & (flush_in ? pend_we_r : {NUM_CH{1'b1}});
        pick_vld = 1'b0;
        pick_idx = '0;
        if (ARB_MODE == 0) begin
            // descending scan: last hit is the lowest index
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    pick_vld = 1'b1;
                    pick_idx = CH_W'(i);
                end
            end
        end else begin
            // descending distance: last hit is the first index after rr_r
            for (int k = NUM_CH; k >= 1; k--) begin
                j = (int'(rr_r) + k) % NUM_CH;
                if (elig[j]) begin
                    pick_vld = 1'b1;
                    pick_idx = CH_W'(j);
                end
            end
        end
    end

    // io_last: the byte currently on the bus is an IO write, so the next IO byte must wait a cycle.
    assign wr_addr     = start_r + ADDR_W'(cnt_r);
    assign wr_byte     = 8'(data_r >> {cnt_r, 3'b000});
    assign rd_merge    = data_r | (DW'(mem_din_in) << {cnt_r, 3'b000});
    assign io_last     = mem_wr_out && (mem_a_out == IO_ADDR);
    assign io_hold_cur = (wr_addr == IO_ADDR) && (io_buffer_full_in || io_last);
    assign io_hold_gnt = (pend_addr_r[pick_idx] == IO_ADDR) && (io_buffer_full_in || io_last);

    // next-state / bus outputs
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        size_nxt  = size_r;
        start_nxt = start_r;
        data_nxt  = data_r;
        gnt_nxt   = gnt_r;
        rr_nxt    = rr_r;
        a_nxt     = mem_a_out;
        dout_nxt  = mem_dout_out;
        wr_nxt    = 1'b0;
        ack_nxt   = '0;
        rdata_nxt = ch_rdata_out;
        gnt_clr   = '0;

        case (state_r)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_clr[pick_idx] = 1'b1;
                    gnt_nxt   = pick_idx;
                    rr_nxt    = pick_idx;
                    start_nxt = pend_addr_r[pick_idx];
                    size_nxt  = pend_size_r[pick_idx];
                    a_nxt     = pend_addr_r[pick_idx];
                    if (pend_we_r[pick_idx]) begin
                        state_nxt = S_WRITE;
                        data_nxt  = pend_wdata_r[pick_idx];
                        if (io_hold_gnt) begin
                            cnt_nxt = 3'd0;
                        end else begin
                            dout_nxt = pend_wdata_r[pick_idx][7:0];
                            wr_nxt   = 1'b1;
                            cnt_nxt  = 3'd1;
                        end
                    end else begin
                        state_nxt = S_READ;
                        data_nxt  = '0;
                        cnt_nxt   = 3'd0;
                    end
                end else begin
                    a_nxt = '0;
                end
            end

            S_READ: begin
                if (flush_in) begin
                    // cancelled read: no ack even on what would have been the last byte
                    state_nxt = S_IDLE;
                    a_nxt     = '0;
                end else begin
                    data_nxt = rd_merge;
                    if (cnt_r == size_r - 3'd1) begin
                        ack_nxt[gnt_r] = 1'b1;
                        rdata_nxt      = rd_merge;
                        state_nxt      = S_IDLE;
                        a_nxt          = '0;
                    end else begin
                        a_nxt   = start_r + ADDR_W'(cnt_r) + ADDR_W'(1);
                        cnt_nxt = cnt_r + 3'd1;
                    end
                end
            end

            S_WRITE: begin
                if (cnt_r == size_r) begin
                    ack_nxt[gnt_r] = 1'b1;
                    state_nxt      = S_IDLE;
                    a_nxt          = '0;
                end else if (!io_hold_cur) begin
                    a_nxt    = wr_addr;
                    dout_nxt = wr_byte;
                    wr_nxt   = 1'b1;
                    cnt_nxt  = cnt_r + 3'd1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                a_nxt     = '0;
            end
        endcase
    end

    // Slot capture only sees an empty slot, so it never collides with a grant clear.
    always_comb begin
        cap_v    = '0;
        pend_nxt = pend_r;
        for (int i = 0; i < NUM_CH; i++) begin
            cap_v[i]    = ch_req_in[i] && !pend_r[i] && (ch_we_in[i] || !flush_in);
            pend_nxt[i] = cap_v[i] ||
                          (pend_r[i] && !gnt_clr[i] && !(flush_in && !pend_we_r[i]));
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r      <= S_IDLE;
            cnt_r        <= '0;
            size_r       <= '0;
            start_r      <= '0;
            data_r       <= '0;
            gnt_r        <= '0;
            rr_r         <= CH_W'(NUM_CH - 1);
            mem_a_out    <= '0;
            mem_dout_out <= '0;
            mem_wr_out   <= 1'b0;
            ch_ack_out   <= '0;
            ch_rdata_out <= '0;
            pend_r       <= '0;
            pend_we_r    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_addr_r[i]  <= '0;
                pend_wdata_r[i] <= '0;
                pend_size_r[i]  <= '0;
            end
        end else if (rdy_in) begin
            state_r      <= state_nxt;
            cnt_r        <= cnt_nxt;
            size_r       <= size_nxt;
            start_r      <= start_nxt;
            data_r       <= data_nxt;
            gnt_r        <= gnt_nxt;
            rr_r         <= rr_nxt;
            mem_a_out    <= a_nxt;
            mem_dout_out <= dout_nxt;
            mem_wr_out   <= wr_nxt;
            ch_ack_out   <= ack_nxt;
            ch_rdata_out <= rdata_nxt;
            pend_r       <= pend_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (cap_v[i]) begin
                    pend_we_r[i]    <= ch_we_in[i];
                    pend_addr_r[i]  <= ch_addr_in[i*ADDR_W +: ADDR_W];
                    pend_wdata_r[i] <= ch_wdata_in[i*DW +: DW];
                    pend_size_r[i]  <= ch_size_in[i*3 +: 3];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Directed bench for mem_arbiter_nch: one round-robin instance (checked throughout)
// and one fixed-priority instance driven identically (checked for grant order).
// Inputs change and outputs are sampled 1ns after the rising edge; bus monitors sample on the falling edge.
module tb_mem_arbiter_nch;

    localparam logic [31:0] IO_A = 32'h0003_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rdy, flush, io_full;
    logic [2:0]  req, we;
    logic [95:0] addr, wdata;
    logic [8:0]  size;

    logic [2:0]  ready, ack, ready_fp, ack_fp;
    logic [31:0] rdata, rdata_fp, a, a_fp;
    logic [7:0]  dout, dout_fp, din, din_fp;
    logic        wr, wr_fp;

    logic [7:0]  ram [0:4095];
    assign din    = ram[a[11:0]];
    assign din_fp = ram[a_fp[11:0]];

    mem_arbiter_nch #(.ARB_MODE(1)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .ch_req_in(req), .ch_we_in(we), .ch_addr_in(addr), .ch_wdata_in(wdata),
        .ch_size_in(size), .ch_ready_out(ready), .ch_ack_out(ack), .ch_rdata_out(rdata),
        .mem_din_in(din), .io_buffer_full_in(io_full), .mem_dout_out(dout),
        .mem_a_out(a), .mem_wr_out(wr)
    );

    mem_arbiter_nch #(.ARB_MODE(0)) dut_fp (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .ch_req_in(req), .ch_we_in(we), .ch_addr_in(addr), .ch_wdata_in(wdata),
        .ch_size_in(size), .ch_ready_out(ready_fp), .ch_ack_out(ack_fp), .ch_rdata_out(rdata_fp),
        .mem_din_in(din_fp), .io_buffer_full_in(io_full), .mem_dout_out(dout_fp),
        .mem_a_out(a_fp), .mem_wr_out(wr_fp)
    );

    // RAM model: contents restored while in reset, written by the round-robin instance only
    logic rdy_q = 1'b0, full_q = 1'b0, prev_io = 1'b0;
    always @(posedge clk) begin
        rdy_q  <= rdy && rst_n;
        full_q <= io_full;
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h11;
            ram[12'h101] <= 8'h22;
            ram[12'h102] <= 8'h33;
            ram[12'h103] <= 8'h44;
        end else if (rdy && wr && a != IO_A) begin
            ram[a[11:0]] <= dout;
        end
    end

    // bus monitor: one entry per enabled cycle
    logic [2:0]  ack_log [$];
    logic [2:0]  ack_log_fp [$];
    logic [39:0] wr_log [$];
    logic [7:0]  io_log [$];
    int          viol = 0;
    always @(negedge clk) begin
        if (rst_n && rdy_q) begin
            if (ack != 3'b000)    ack_log.push_back(ack);
            if (ack_fp != 3'b000) ack_log_fp.push_back(ack_fp);
            if ($countones(ack) > 1) viol <= viol + 1;
            if (wr && a == IO_A) begin
                io_log.push_back(dout);
                if (full_q || prev_io) viol <= viol + 1;
            end else if (wr) begin
                wr_log.push_back({a, dout});
            end
            prev_io <= wr && (a == IO_A);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic send(input int ch, input logic w, input logic [31:0] ad,
                        input logic [31:0] d, input logic [2:0] sz);
        req[ch]           = 1'b1;
        we[ch]            = w;
        addr[ch*32 +: 32] = ad;
        wdata[ch*32 +: 32] = d;
        size[ch*3 +: 3]   = sz;
    endtask

    // cycles from the edge after capture until ack is seen; 40 means it never came
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == 3'b000 && n < 40);
    endtask

    function automatic logic [39:0] beat(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return '1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n, b, bf, wb, ib, vb;
        logic [11:0] seq, seqf;
        logic [23:0] iob;

        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0; size = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 3'b111);
        check("rst_ack",   ack, 3'b000);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addr",  a, 32'h0);
        check("rst_dout",  dout, 8'h0);
        check("rst_wr",    wr, 1'b0);
        rst_n = 1'b1;
        tick();

        // single 4-byte read
        send(1, 1'b0, 32'h100, 32'h0, 3'd4); tick(); req = '0;
        wait_ack(n);
        check("rd4_lat",  n, 5);
        check("rd4_ack",  ack, 3'b010);
        check("rd4_data", rdata, 32'h4433_2211);
        tick();
        check("ack_pulse", ack, 3'b000);
        idle(2);

        // 1-byte read: upper bytes zero
        send(2, 1'b0, 32'h101, 32'h0, 3'd1); tick(); req = '0;
        wait_ack(n);
        check("rd1_lat",  n, 2);
        check("rd1_data", rdata, 32'h0000_0022);
        idle(3);

        // simultaneous requests, ch0 re-requests right after its grant
        b = ack_log.size(); bf = ack_log_fp.size();
        send(0, 1'b0, 32'h100, 32'h0, 3'd1);
        send(1, 1'b0, 32'h101, 32'h0, 3'd1);
        send(2, 1'b0, 32'h102, 32'h0, 3'd1);
        tick(); req = '0;
        tick();
        check("gnt_free", ready, 3'b001);
        send(0, 1'b0, 32'h103, 32'h0, 3'd1); tick(); req = '0;
        idle(12);
        seq = '0; seqf = '0;
        for (int i = 0; i < 4; i++) begin
            if (b + i < ack_log.size())     seq[11-3*i -: 3]  = ack_log[b+i];
            if (bf + i < ack_log_fp.size()) seqf[11-3*i -: 3] = ack_log_fp[bf+i];
        end
        check("arb_count", ack_log.size() - b, 4);
        check("rr_order",  seq,  12'b001_010_100_001);
        check("fp_order",  seqf, 12'b001_001_010_100);

        // 2-byte write
        wb = wr_log.size();
        send(1, 1'b1, 32'h200, 32'h0000_ABCD, 3'd2); tick(); req = '0;
        wait_ack(n);
        check("wr_lat",    n, 3);
        check("wr_ack",    ack, 3'b010);
        check("wr_ack_wr", wr, 1'b0);
        idle(2);
        check("wr_beats", wr_log.size() - wb, 2);
        check("wr_beat0", beat(wb),     {32'h200, 8'hCD});
        check("wr_beat1", beat(wb + 1), {32'h201, 8'hAB});
        check("ram_200",  ram[12'h200], 8'hCD);
        check("ram_201",  ram[12'h201], 8'hAB);

        // address wrap
        wb = wr_log.size();
        send(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 3'd2); tick(); req = '0;
        wait_ack(n);
        idle(2);
        check("wrap_beat0", beat(wb),     {32'hFFFF_FFFF, 8'h34});
        check("wrap_beat1", beat(wb + 1), {32'h0000_0000, 8'h12});

        // IO pacing: buffer full at three edges
        ib = io_log.size(); vb = viol;
        io_full = 1'b1;
        send(0, 1'b1, IO_A, 32'h41, 3'd1); tick(); req = '0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 2) io_full = 1'b0;
        end while (ack == 3'b000 && n < 40);
        check("io_lat", n, 4);
        idle(2);
        send(1, 1'b1, IO_A, 32'h42, 3'd1); tick(); req = '0;
        wait_ack(n);
        check("io_lat2", n, 2);
        idle(2);
        send(2, 1'b1, IO_A, 32'h43, 3'd1); tick(); req = '0;
        wait_ack(n);
        idle(2);
        iob = '1;
        if (io_log.size() >= ib + 3) iob = {io_log[ib], io_log[ib+1], io_log[ib+2]};
        check("io_count", io_log.size() - ib, 3);
        check("io_bytes", iob, 24'h414243);
        check("io_viol",  viol - vb, 0);

        // flush in the 3rd read cycle; read req dropped, write req kept on the flush edge
        b = ack_log.size();
        send(0, 1'b0, 32'h100, 32'h0, 3'd4); tick(); req = '0;
        tick();
        send(1, 1'b0, 32'h101, 32'h0, 3'd1); tick(); req = '0;
        check("fl_pend", ready, 3'b101);
        tick();
        flush = 1'b1;
        send(0, 1'b0, 32'h102, 32'h0, 3'd1);
        send(2, 1'b1, 32'h300, 32'h5A, 3'd1);
        tick(); flush = 1'b0; req = '0;
        check("fl_no_ack", ack, 3'b000);
        check("fl_ready",  ready, 3'b011);
        wait_ack(n);
        check("fl_wr_ack", ack, 3'b100);
        check("fl_wr_lat", n, 2);
        idle(4);
        check("fl_acks",  ack_log.size() - b, 1);
        check("fl_ram",   ram[12'h300], 8'h5A);
        check("fl_ready_end", ready, 3'b111);

        // stall for 4 cycles mid-read
        send(1, 1'b0, 32'h100, 32'h0, 3'd4); tick(); req = '0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 2) rdy = 1'b0;
            if (n == 6) begin
                check("stall_addr", a, 32'h101);
                check("stall_ack",  ack, 3'b000);
                rdy = 1'b1;
            end
        end while (ack == 3'b000 && n < 40);
        check("stall_lat",  n, 9);
        check("stall_data", rdata, 32'h4433_2211);
        idle(3);

        // reset in the middle of a write
        b = ack_log.size();
        send(0, 1'b1, 32'h400, 32'hDEAD_BEEF, 3'd4); tick(); req = '0;
        tick();
        send(1, 1'b0, 32'h100, 32'h0, 3'd1); tick(); req = '0;
        check("rst_pre_wr",   wr, 1'b1);
        check("rst_pre_addr", a, 32'h401);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr",    wr, 1'b0);
        check("rst_mid_ready", ready, 3'b111);
        check("rst_mid_addr",  a, 32'h0);
        tick();
        rst_n = 1'b1;
        idle(8);
        check("rst_no_ack",  ack_log.size() - b, 0);
        check("rst_idle_wr", wr, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
